// File: rtl/move_dispatch_if.sv
// Request/response and checker-side bundle for move_dispatch.
// slave: the dispatcher. master: the game-play controller plus the checkers.
interface move_dispatch_if #(
  parameter int unsigned NUM_CHK = 6
);
  logic                    req_valid;
  logic                    req_ready;
  logic [2:0]              req_old_x;
  logic [2:0]              req_old_y;
  logic [2:0]              req_new_x;
  logic [2:0]              req_new_y;
  // Indexed [y][x]; 4'd15 = empty, bit3 = colour, bits[2:0] = type
  logic [7:0][7:0][3:0]    board_in;
  logic [2:0]              old_x;
  logic [2:0]              old_y;
  logic [2:0]              new_x;
  logic [2:0]              new_y;
  logic [2:0]              h_delta;
  logic [2:0]              v_delta;
  logic [3:0]              piece_type;
  logic [NUM_CHK-1:0]      chk_start;
  logic [NUM_CHK-1:0]      chk_valid_move;
  logic [NUM_CHK-1:0]      chk_valid_output;
  logic                    resp_valid;
  logic                    resp_legal;
  logic [2:0]              resp_code;

  modport slave (
    input  req_valid, req_old_x, req_old_y, req_new_x, req_new_y, board_in,
    input  chk_valid_move, chk_valid_output,
    output req_ready, old_x, old_y, new_x, new_y, h_delta, v_delta, piece_type,
    output chk_start, resp_valid, resp_legal, resp_code
  );

  modport master (
    output req_valid, req_old_x, req_old_y, req_new_x, req_new_y, board_in,
    output chk_valid_move, chk_valid_output,
    input  req_ready, old_x, old_y, new_x, new_y, h_delta, v_delta, piece_type,
    input  chk_start, resp_valid, resp_legal, resp_code
  );
endinterface

// File: rtl/move_dispatch.sv
// Move dispatcher: decodes the moving piece, runs piece-independent pre-checks,
// launches the per-piece path checker and returns one legal/illegal verdict.
// Optional feature macro: TURN_ENFORCE_EN (side-to-move enforcement, code 4).
module move_dispatch #(
  parameter int unsigned NUM_CHK = 6,
  parameter int unsigned TIMEOUT = 16
) (
  input logic           clk,
  input logic           reset_n,
  move_dispatch_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StDecode, StDispatch, StWait, StResp} state_e;

  localparam logic [2:0] CodeOk       = 3'd0;
  localparam logic [2:0] CodeEmpty    = 3'd1;
  localparam logic [2:0] CodeNull     = 3'd2;
  localparam logic [2:0] CodeFriendly = 3'd3;
`ifdef TURN_ENFORCE_EN
  localparam logic [2:0] CodeSide     = 3'd4;
`endif
  localparam logic [2:0] CodeReject   = 3'd5;
  localparam logic [2:0] CodeTimeout  = 3'd6;
  localparam logic [2:0] CodeBadPiece = 3'd7;
  localparam logic [3:0] Empty        = 4'd15;
  localparam logic [7:0] TimeoutLast  = 8'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [2:0]         old_x_q, old_x_d, old_y_q, old_y_d;
  logic [2:0]         new_x_q, new_x_d, new_y_q, new_y_d;
  logic [2:0]         h_delta_q, h_delta_d, v_delta_q, v_delta_d;
  logic [3:0]         piece_type_q, piece_type_d;
  logic [NUM_CHK-1:0] chk_start_q, chk_start_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_legal_q, resp_legal_d;
  logic [2:0]         resp_code_q, resp_code_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               sticky_q, sticky_d;
`ifdef TURN_ENFORCE_EN
  logic               side_q, side_d;  // 0 = white to move
`endif

  logic [3:0]         src_code, dst_code;
  logic               pre_fail;
  logic [2:0]         pre_code;
  logic [NUM_CHK-1:0] sel_onehot;
  logic               sel_move, sel_done, wait_legal;

  function automatic logic [NUM_CHK-1:0] type_onehot(input logic [2:0] t);
    logic [NUM_CHK-1:0] oh;
    oh = '0;
    for (int i = 0; i < int'(NUM_CHK); i++) begin
      if (int'(t) == i) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Coordinates are 0..7, so the 3-bit absolute difference is exact
  function automatic logic [2:0] abs_diff(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[3]) d = 4'd0 - d;
    return d[2:0];
  endfunction

  assign src_code   = bus.board_in[old_y_q][old_x_q];
  assign dst_code   = bus.board_in[new_y_q][new_x_q];
  assign sel_onehot = type_onehot(piece_type_q[2:0]);
  assign sel_move   = |(bus.chk_valid_move & sel_onehot);
  assign sel_done   = |(bus.chk_valid_output & sel_onehot);
  assign wait_legal = sticky_q | sel_move;

  // Next-state, pre-check decode and registered-output next values
  always_comb begin
    state_d      = state_q;
    old_x_d      = old_x_q;
    old_y_d      = old_y_q;
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;
    h_delta_d    = h_delta_q;
    v_delta_d    = v_delta_q;
    piece_type_d = piece_type_q;
    chk_start_d  = '0;
    resp_valid_d = 1'b0;
    resp_legal_d = resp_legal_q;
    resp_code_d  = resp_code_q;
    cnt_d        = cnt_q;
    sticky_d     = sticky_q;
`ifdef TURN_ENFORCE_EN
    side_d       = side_q;
`endif

    // Pre-checks in priority order: empty, null, bad code, side, friendly
    pre_fail = 1'b1;
    pre_code = CodeOk;
    if (src_code == Empty) begin
      pre_code = CodeEmpty;
    end else if ((old_x_q == new_x_q) && (old_y_q == new_y_q)) begin
      pre_code = CodeNull;
    end else if (src_code[2:1] == 2'b11) begin
      pre_code = CodeBadPiece;
`ifdef TURN_ENFORCE_EN
    end else if (src_code[3] != side_q) begin
      pre_code = CodeSide;
`endif
    end else if ((dst_code != Empty) && (dst_code[3] == src_code[3])) begin
      pre_code = CodeFriendly;
    end else begin
      pre_fail = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          old_x_d = bus.req_old_x;
          old_y_d = bus.req_old_y;
          new_x_d = bus.req_new_x;
          new_y_d = bus.req_new_y;
          state_d = StDecode;
        end
      end
      StDecode: begin
        piece_type_d = src_code;
        h_delta_d    = abs_diff(new_x_q, old_x_q);
        v_delta_d    = abs_diff(new_y_q, old_y_q);
        if (pre_fail) begin
          resp_valid_d = 1'b1;
          resp_legal_d = 1'b0;
          resp_code_d  = pre_code;
          state_d      = StResp;
        end else begin
          chk_start_d = type_onehot(src_code[2:0]);
          state_d     = StDispatch;
        end
      end
      StDispatch: begin
        cnt_d    = '0;
        sticky_d = 1'b0;
        state_d  = StWait;
      end
      StWait: begin
        // A done strobe in the last allowed cycle still wins over the timeout
        if (sel_done) begin
          resp_valid_d = 1'b1;
          resp_legal_d = wait_legal;
          resp_code_d  = wait_legal ? CodeOk : CodeReject;
          state_d      = StResp;
        end else if (cnt_q == TimeoutLast) begin
          resp_valid_d = 1'b1;
          resp_legal_d = 1'b0;
          resp_code_d  = CodeTimeout;
          state_d      = StResp;
        end else begin
          cnt_d    = cnt_q + 8'd1;
          sticky_d = wait_legal;
        end
      end
      StResp: begin
`ifdef TURN_ENFORCE_EN
        if (resp_legal_q) side_d = ~side_q;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      old_x_q      <= '0;
      old_y_q      <= '0;
      new_x_q      <= '0;
      new_y_q      <= '0;
      h_delta_q    <= '0;
      v_delta_q    <= '0;
      piece_type_q <= Empty;
      chk_start_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_legal_q <= 1'b0;
      resp_code_q  <= CodeOk;
      cnt_q        <= '0;
      sticky_q     <= 1'b0;
`ifdef TURN_ENFORCE_EN
      side_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      old_x_q      <= old_x_d;
      old_y_q      <= old_y_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      h_delta_q    <= h_delta_d;
      v_delta_q    <= v_delta_d;
      piece_type_q <= piece_type_d;
      chk_start_q  <= chk_start_d;
      resp_valid_q <= resp_valid_d;
      resp_legal_q <= resp_legal_d;
      resp_code_q  <= resp_code_d;
      cnt_q        <= cnt_d;
      sticky_q     <= sticky_d;
`ifdef TURN_ENFORCE_EN
      side_q       <= side_d;
`endif
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.old_x      = old_x_q;
  assign bus.old_y      = old_y_q;
  assign bus.new_x      = new_x_q;
  assign bus.new_y      = new_y_q;
  assign bus.h_delta    = h_delta_q;
  assign bus.v_delta    = v_delta_q;
  assign bus.piece_type = piece_type_q;
  assign bus.chk_start  = chk_start_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_legal = resp_legal_q;
  assign bus.resp_code  = resp_code_q;

endmodule

// File: tb/tb_move_dispatch.sv
// Self-checking bench for move_dispatch: a vector table of single requests
// plus hand-written sequences for reset abort, back-to-back and turn order.
module tb_move_dispatch;
  localparam int unsigned NumChk  = 6;
  localparam int unsigned Timeout = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  move_dispatch_if #(.NUM_CHK(NumChk)) bus ();

  move_dispatch #(.NUM_CHK(NumChk), .TIMEOUT(Timeout)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int         ox, oy, nx, ny;
    logic [3:0] src, dst;
    int         vm_k, done_k, idx;  // checker stimulus, cycles after accept
    logic [5:0] start;              // expected chk_start (0 = never)
    int         resp_k, legal, code, h, v;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    bus.req_valid        = 1'b0;
    bus.chk_valid_move   = '0;
    bus.chk_valid_output = '0;
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic clear_board();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) bus.board_in[y][x] = 4'd15;
  endtask

  task automatic set_board(input int ox, oy, nx, ny, input logic [3:0] src, dst);
    clear_board();
    bus.board_in[ny][nx] = dst;
    bus.board_in[oy][ox] = src;
  endtask

  task automatic drive_req(input int ox, oy, nx, ny);
    bus.req_valid = 1'b1;
    bus.req_old_x = 3'(ox);
    bus.req_old_y = 3'(oy);
    bus.req_new_x = 3'(nx);
    bus.req_new_y = 3'(ny);
  endtask

  // Issue one request from IDLE, act as checker, and record what came back.
  // Cycle k counts from the accept edge: k=1 is the cycle after acceptance.
  task automatic run_req(input int ox, oy, nx, ny, vm_k, done_k, idx,
                         output logic [5:0] st_val, output int st_k, pulses,
                         output int rk, lg, cd, h, v, pt);
    st_val = '0; st_k = 0; pulses = 0; rk = 0; lg = 0; cd = 0; h = 0; v = 0; pt = 0;
    @(posedge clk);
    #1;
    drive_req(ox, oy, nx, ny);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (bus.chk_start != '0) begin
        pulses++;
        if (st_k == 0) begin
          st_k   = k;
          st_val = bus.chk_start;
        end
      end
      if (bus.resp_valid) begin
        rk = k;
        lg = int'(bus.resp_legal);
        cd = int'(bus.resp_code);
        h  = int'(bus.h_delta);
        v  = int'(bus.v_delta);
        pt = int'(bus.piece_type);
        break;
      end
      bus.chk_valid_move   = (k == vm_k)   ? (6'd1 << idx) : 6'd0;
      bus.chk_valid_output = (k == done_k) ? (6'd1 << idx) : 6'd0;
    end
    bus.chk_valid_move   = '0;
    bus.chk_valid_output = '0;
  endtask

  logic [5:0] st_val;
  int st_k, pulses, rk, lg, cd, h, v, pt;
  int bad_cnt;

  initial begin
    //          ox oy nx ny src    dst    vm  dn idx start      rk lg cd h  v
    vecs[0]  = '{3, 0, 3, 4, 4'd4,  4'd15, 3,  4, 4, 6'b010000, 5, 1, 0, 0, 4};
    vecs[1]  = '{4, 4, 4, 5, 4'd15, 4'd15, 0,  0, 0, 6'b000000, 2, 0, 1, 0, 1};
    vecs[2]  = '{0, 0, 0, 6, 4'd3,  4'd0,  0,  0, 0, 6'b000000, 2, 0, 3, 0, 6};
    vecs[3]  = '{0, 0, 0, 6, 4'd3,  4'd8,  0,  5, 3, 6'b001000, 6, 0, 5, 0, 6};
    vecs[4]  = '{1, 0, 2, 2, 4'd1,  4'd15, 5,  5, 0, 6'b000010, 19, 0, 6, 1, 2};
    vecs[5]  = '{2, 2, 2, 2, 4'd2,  4'd2,  0,  0, 0, 6'b000000, 2, 0, 2, 0, 0};
    vecs[6]  = '{5, 5, 5, 5, 4'd15, 4'd15, 0,  0, 0, 6'b000000, 2, 0, 1, 0, 0};
    vecs[7]  = '{7, 7, 0, 0, 4'd7,  4'd0,  0,  0, 0, 6'b000000, 2, 0, 7, 7, 7};
    vecs[8]  = '{1, 1, 1, 1, 4'd14, 4'd14, 0,  0, 0, 6'b000000, 2, 0, 2, 0, 0};
    vecs[9]  = '{0, 0, 3, 3, 4'd2,  4'd15, 3,  6, 2, 6'b000100, 7, 1, 0, 3, 3};
    vecs[10] = '{6, 5, 2, 1, 4'd5,  4'd15, 3,  3, 5, 6'b100000, 4, 1, 0, 4, 4};
`ifdef TURN_ENFORCE_EN
    vecs[11] = '{0, 6, 0, 5, 4'd8,  4'd15, 4,  4, 0, 6'b000000, 2, 0, 4, 0, 1};
`else
    vecs[11] = '{0, 6, 0, 5, 4'd8,  4'd15, 4,  4, 0, 6'b000001, 5, 1, 0, 0, 1};
`endif
    // valid_move during DISPATCH must not count toward the sticky flag
    vecs[12] = '{3, 3, 4, 4, 4'd0,  4'd9,  2,  3, 0, 6'b000001, 4, 0, 5, 1, 1};
    // done in the last WAIT cycle beats the timeout
    vecs[13] = '{0, 0, 7, 7, 4'd4,  4'd15, 18, 18, 4, 6'b010000, 19, 1, 0, 7, 7};

    clear_board();
    bus.req_old_x = '0; bus.req_old_y = '0; bus.req_new_x = '0; bus.req_new_y = '0;
    do_reset();
    check("rst_ready", int'(bus.req_ready), 1);
    check("rst_chk_start", int'(bus.chk_start), 0);
    check("rst_resp_valid", int'(bus.resp_valid), 0);
    check("rst_resp_legal", int'(bus.resp_legal), 0);
    check("rst_resp_code", int'(bus.resp_code), 0);
    check("rst_piece_type", int'(bus.piece_type), 15);
    check("rst_h_delta", int'(bus.h_delta), 0);

    for (int i = 0; i < 14; i++) begin
      do_reset();
      set_board(vecs[i].ox, vecs[i].oy, vecs[i].nx, vecs[i].ny, vecs[i].src, vecs[i].dst);
      run_req(vecs[i].ox, vecs[i].oy, vecs[i].nx, vecs[i].ny, vecs[i].vm_k, vecs[i].done_k,
              vecs[i].idx, st_val, st_k, pulses, rk, lg, cd, h, v, pt);
      check($sformatf("v%0d_start", i), int'(st_val), int'(vecs[i].start));
      check($sformatf("v%0d_start_k", i), st_k, (vecs[i].start != '0) ? 2 : 0);
      check($sformatf("v%0d_pulses", i), pulses, (vecs[i].start != '0) ? 1 : 0);
      check($sformatf("v%0d_resp_k", i), rk, vecs[i].resp_k);
      check($sformatf("v%0d_legal", i), lg, vecs[i].legal);
      check($sformatf("v%0d_code", i), cd, vecs[i].code);
      check($sformatf("v%0d_h", i), h, vecs[i].h);
      check($sformatf("v%0d_v", i), v, vecs[i].v);
      check($sformatf("v%0d_ptype", i), pt, int'(vecs[i].src));
    end

    // Reset pulse during WAIT aborts the move silently
    do_reset();
    set_board(3, 0, 3, 4, 4'd4, 4'd15);
    @(posedge clk);
    #1;
    drive_req(3, 0, 3, 4);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("abort_ready", int'(bus.req_ready), 1);
    check("abort_ptype", int'(bus.piece_type), 15);
    check("abort_v_delta", int'(bus.v_delta), 0);
    check("abort_new_y", int'(bus.new_y), 0);
    bad_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      bus.chk_valid_output = (k == 1) ? 6'b010000 : 6'd0;
      bus.chk_valid_move   = (k == 1) ? 6'b010000 : 6'd0;
      @(posedge clk);
      #1;
      if (bus.resp_valid || (bus.chk_start != '0)) bad_cnt++;
    end
    bus.chk_valid_output = '0;
    bus.chk_valid_move   = '0;
    check("abort_no_activity", bad_cnt, 0);
    check("abort_ready_end", int'(bus.req_ready), 1);

    // Back-to-back: request held through RESP is taken in the next IDLE cycle
    do_reset();
    clear_board();
    bus.board_in[0][3] = 4'd4;
    @(posedge clk);
    #1;
    drive_req(4, 4, 4, 5);
    @(posedge clk);
    #1;
    drive_req(3, 0, 3, 0);
    @(posedge clk);
    #1;
    check("b2b_resp1_valid", int'(bus.resp_valid), 1);
    check("b2b_resp1_code", int'(bus.resp_code), 1);
    check("b2b_resp_not_ready", int'(bus.req_ready), 0);
    @(posedge clk);
    #1;
    check("b2b_idle_ready", int'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("b2b_decode_quiet", int'(bus.resp_valid), 0);
    @(posedge clk);
    #1;
    check("b2b_resp2_valid", int'(bus.resp_valid), 1);
    check("b2b_resp2_code", int'(bus.resp_code), 2);

`ifdef TURN_ENFORCE_EN
    // White legal, black legal, then white again is accepted; white twice is not
    do_reset();
    clear_board();
    bus.board_in[0][3] = 4'd4;
    bus.board_in[6][0] = 4'd8;
    run_req(3, 0, 3, 4, 3, 4, 4, st_val, st_k, pulses, rk, lg, cd, h, v, pt);
    check("turn_w1_legal", lg, 1);
    run_req(0, 6, 0, 5, 4, 4, 0, st_val, st_k, pulses, rk, lg, cd, h, v, pt);
    check("turn_b_legal", lg, 1);
    check("turn_b_start", int'(st_val), 1);
    run_req(3, 0, 3, 3, 0, 5, 4, st_val, st_k, pulses, rk, lg, cd, h, v, pt);
    check("turn_w2_code", cd, 5);
    run_req(3, 0, 3, 2, 3, 4, 4, st_val, st_k, pulses, rk, lg, cd, h, v, pt);
    check("turn_w3_legal", lg, 1);
    run_req(3, 0, 3, 3, 3, 4, 4, st_val, st_k, pulses, rk, lg, cd, h, v, pt);
    check("turn_w4_code", cd, 4);
    check("turn_w4_resp_k", rk, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
